// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register carrying a control and a data field under valid/ready,
// with flush and bubble insertion; SKID=1 adds a second entry so ready_o is a flop.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 138,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic                ready_w;
  logic                accept;
  logic                xfer;

  assign valid_o = (state_q != ST_EMPTY);
  assign accept  = valid_i & ready_w;
  assign xfer    = valid_o & ready_i;
  assign ready_o = ready_w;
  assign ctrl_o  = valid_o ? main_ctrl_q : '0;
  assign data_o  = main_data_q;
  assign count_o = state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;
      logic              ready_q, ready_d;

      always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              main_ctrl_d = ctrl_i;
              main_data_d = data_i;
              state_d     = ST_FULL;
            end
          end
          ST_FULL: begin
            if (xfer && accept) begin
              main_ctrl_d = ctrl_i;
              main_data_d = data_i;
            end else if (xfer) begin
              state_d = ST_EMPTY;
            end else if (accept) begin
              skid_ctrl_d = ctrl_i;
              skid_data_d = data_i;
              state_d     = ST_SKID_FULL;
            end
          end
          ST_SKID_FULL: begin
            if (xfer) begin
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              state_d     = ST_FULL;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        // A flushed cycle loads nothing, so a killed entry never reaches data_o.
        if (flush_i) begin
          state_d     = ST_EMPTY;
          main_ctrl_d = main_ctrl_q;
          main_data_d = main_data_q;
          skid_ctrl_d = skid_ctrl_q;
          skid_data_d = skid_data_q;
        end
        ready_d = (state_d != ST_SKID_FULL);
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
          ready_q     <= 1'b1;
        end else begin
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
          ready_q     <= ready_d;
        end
      end

      assign ready_w = ready_q;
    end else begin : g_single
      assign ready_w = ~valid_o | ready_i;

      always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              main_ctrl_d = ctrl_i;
              main_data_d = data_i;
              state_d     = ST_FULL;
            end
          end
          ST_FULL: begin
            if (xfer && accept) begin
              main_ctrl_d = ctrl_i;
              main_data_d = data_i;
            end else if (xfer) begin
              state_d = ST_EMPTY;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
          state_d     = ST_EMPTY;
          main_ctrl_d = main_ctrl_q;
          main_data_d = main_data_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of the default skid build, then a random scoreboard run
// against a SKID=0 build with narrower fields.
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst_n;

  logic         valid_i, ready_i, flush_i;
  logic [7:0]   ctrl_i;
  logic [137:0] data_i;
  logic         ready_o, valid_o;
  logic [7:0]   ctrl_o;
  logic [137:0] data_o;
  logic [1:0]   count_o;

  logic         b_valid_i, b_ready_i, b_flush_i;
  logic [3:0]   b_ctrl_i;
  logic [63:0]  b_data_i;
  logic         b_ready_o, b_valid_o;
  logic [3:0]   b_ctrl_o;
  logic [63:0]  b_data_o;
  logic [1:0]   b_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .ctrl_i(ctrl_i), .data_i(data_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .ctrl_o(ctrl_o), .data_o(data_o), .count_o(count_o)
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(64), .SKID(1'b0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .ctrl_i(b_ctrl_i), .data_i(b_data_i),
    .flush_i(b_flush_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .ctrl_o(b_ctrl_o), .data_o(b_data_o), .count_o(b_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [137:0] d,
                       input logic r, input logic f);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] c,
                           input logic [137:0] d, input logic [1:0] n, input logic r);
    check({tag, "_valid"}, valid_o, v);
    check({tag, "_ctrl"},  ctrl_o,  c);
    check({tag, "_data"},  data_o,  d);
    check({tag, "_count"}, count_o, n);
    check({tag, "_ready"}, ready_o, r);
  endtask

  logic [67:0] sb_q[$];
  logic        exp_ready;
  logic [67:0] head;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    b_valid_i = 1'b0; b_ready_i = 1'b0; b_flush_i = 1'b0;
    b_ctrl_i = '0; b_data_i = '0;
    #12;
    check_out("rst", 1'b0, 8'h00, '0, 2'd0, 1'b1);
    check("rst_b_valid", b_valid_o, 1'b0);
    rst_n = 1'b1;

    // Streaming: one entry per cycle, one cycle of latency.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'hA5, 138'(i), 1'b1, 1'b0);
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, 8'hA5, 138'(i), 2'd1, 1'b1);
    end
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    tick();
    check_out("stream_drain", 1'b0, 8'h00, 138'h8, 2'd0, 1'b1);

    // Skid stall: 0x11 lands in skid, 0x12 waits upstream.
    drive(1'b1, 8'h11, 138'h10, 1'b1, 1'b0);
    tick();
    check_out("skid_a", 1'b1, 8'h11, 138'h10, 2'd1, 1'b1);
    drive(1'b1, 8'h22, 138'h11, 1'b0, 1'b0);
    tick();
    check_out("skid_b", 1'b1, 8'h11, 138'h10, 2'd2, 1'b0);
    drive(1'b1, 8'h33, 138'h12, 1'b0, 1'b0);
    tick();
    check_out("skid_c", 1'b1, 8'h11, 138'h10, 2'd2, 1'b0);
    drive(1'b1, 8'h33, 138'h12, 1'b1, 1'b0);
    tick();
    check_out("skid_d", 1'b1, 8'h22, 138'h11, 2'd1, 1'b1);
    tick();
    check_out("skid_e", 1'b1, 8'h33, 138'h12, 2'd1, 1'b1);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    tick();
    check_out("skid_f", 1'b0, 8'h00, 138'h12, 2'd0, 1'b1);

    // Bubble: gap with ctrl_i all ones must not leak to ctrl_o.
    drive(1'b1, 8'h3C, 138'h20, 1'b1, 1'b0);
    tick();
    check_out("bub_a", 1'b1, 8'h3C, 138'h20, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'hFF, 138'hDEAD, 1'b1, 1'b0);
      tick();
      check_out($sformatf("bub_gap%0d", i), 1'b0, 8'h00, 138'h20, 2'd0, 1'b1);
    end
    drive(1'b1, 8'h5A, 138'h21, 1'b1, 1'b0);
    tick();
    check_out("bub_b", 1'b1, 8'h5A, 138'h21, 2'd1, 1'b1);

    // Flush from SKID_FULL with a new entry offered.
    drive(1'b1, 8'h44, 138'h30, 1'b0, 1'b0);
    tick();
    check_out("fl_a", 1'b1, 8'h5A, 138'h21, 2'd2, 1'b0);
    drive(1'b1, 8'h55, 138'h31, 1'b0, 1'b1);
    tick();
    check_out("fl_b", 1'b0, 8'h00, 138'h21, 2'd0, 1'b1);
    drive(1'b0, 8'h00, '0, 1'b1, 1'b0);
    tick();
    check_out("fl_c", 1'b0, 8'h00, 138'h21, 2'd0, 1'b1);

    // Flush from FULL while an accept happens: the accepted entry is discarded.
    drive(1'b1, 8'h66, 138'h40, 1'b0, 1'b0);
    tick();
    check_out("fl_d", 1'b1, 8'h66, 138'h40, 2'd1, 1'b1);
    drive(1'b1, 8'h77, 138'h41, 1'b0, 1'b1);
    tick();
    check_out("fl_e", 1'b0, 8'h00, 138'h40, 2'd0, 1'b1);

    // Asynchronous reset in the middle of a cycle with two entries held.
    drive(1'b1, 8'h88, 138'h50, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h99, 138'h51, 1'b0, 1'b0);
    tick();
    check_out("ar_a", 1'b1, 8'h88, 138'h50, 2'd2, 1'b0);
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("ar_b", 1'b0, 8'h00, '0, 2'd0, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();
    check_out("ar_c", 1'b0, 8'h00, '0, 2'd0, 1'b1);

    // SKID=0 build: random handshakes against an in-order scoreboard.
    for (int c = 0; c < 1000; c++) begin
      b_valid_i = 1'($urandom_range(0, 1));
      b_ready_i = 1'($urandom_range(0, 1));
      b_ctrl_i  = 4'($urandom);
      b_data_i  = {$urandom, $urandom};
      #1;
      exp_ready = (sb_q.size() == 0) || b_ready_i;
      check("s0_valid", b_valid_o, sb_q.size() != 0);
      check("s0_ready", b_ready_o, exp_ready);
      if (sb_q.size() != 0) begin
        head = sb_q[0];
        check("s0_entry", {b_ctrl_o, b_data_o}, head);
        if (b_ready_i) void'(sb_q.pop_front());
      end else begin
        check("s0_bubble_ctrl", b_ctrl_o, 4'h0);
      end
      if (b_valid_i && exp_ready) sb_q.push_back({b_ctrl_i, b_data_i});
      tick();
    end
    b_valid_i = 1'b0;
    b_ready_i = 1'b1;
    tick();
    tick();
    check("s0_drained", b_valid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that supersedes the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a control field and a data field between two pipeline stages using a valid/ready handshake, with stall, flush and bubble insertion. An optional two-entry skid mode gives a fully registered `ready_o` for long-path stages. It sits between any two adjacent CPU stages.

## Interface
- `CTRL_W`, default 8: control-field width. Default is the ID/EX set: Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite.
- `DATA_W`, default 138: data-field width. Default is pc 32 + RS1data 32 + RS2data 32 + imm 32 + funct 10.
- `SKID`, default 1: 1 selects the two-entry skid buffer with registered `ready_o`; 0 selects a single register with combinational `ready_o`.
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: upstream presents an entry.
- `ready_o` out 1: block can accept an entry this cycle.
- `ctrl_i` in CTRL_W: upstream control field.
- `data_i` in DATA_W: upstream data field.
- `flush_i` in 1: synchronous kill of all held entries and the incoming one.
- `valid_o` out 1: an entry is presented downstream.
- `ready_i` in 1: downstream accepts this cycle.
- `ctrl_o` out CTRL_W: control field. Forced to 0 whenever `valid_o`=0 (bubble).
- `data_o` out DATA_W: data field of the head entry. Holds its last value when invalid.
- `count_o` out 2: number of entries held (0..2; 0..1 when SKID=0).

## Operation
- Accept occurs when `valid_i & ready_o`. Downstream transfer occurs when `valid_o & ready_i`.
- Storage is a main register (head, drives outputs) and, when SKID=1, a skid register.
- State machine for SKID=1 is EMPTY / FULL / SKID_FULL, encoded as `count_o` 0 / 1 / 2.
  - EMPTY: accept → FULL with main loaded. Otherwise stay.
  - FULL, transfer and accept: main reloaded, stay FULL.
  - FULL, transfer, no accept: → EMPTY.
  - FULL, no transfer, accept: skid loaded, → SKID_FULL.
  - FULL, no transfer, no accept: hold.
  - SKID_FULL: `ready_o`=0, so no accept. On transfer, main ← skid and → FULL. Otherwise hold.
- `ready_o` for SKID=1 is a flop, equal to `state != SKID_FULL`. It never depends on `ready_i` combinationally.
- SKID=0 has states EMPTY / FULL only. `ready_o` = `!valid_o | ready_i` (combinational). The skid register is not instantiated.
- `valid_o` = `state != EMPTY`.
- `ctrl_o` = `valid_o ? main_ctrl : 0`. Downstream therefore never sees RegWrite or MemWrite asserted on a bubble.
- Flush:
  - `flush_i`=1 forces the next state to EMPTY.
  - The entry accepted in the same cycle is discarded.
  - Data registers are not cleared.
  - `ready_o` is 1 in the next cycle.
- Priority: reset > flush > normal handshake.
- Stall is expressed only through `ready_i`=0. No separate stall port.

## Timing
- Reset (asynchronous, while `rst_n_i`=0): state EMPTY, `valid_o`=0, `ctrl_o`=0, `data_o`=0, `count_o`=0, `ready_o`=1. Skid data registers are also reset to 0.
- Reset asserted mid-operation: all held entries are lost immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N is visible on `valid_o`/`ctrl_o`/`data_o` after edge N.
- Throughput: 1 entry/cycle with `ready_i` held 1, both modes.
- SKID=1 stall: after `ready_i` falls, at most 1 further entry is accepted (into skid). `ready_o` deasserts the cycle after that accept.
- Order is strictly FIFO. Skid contents always follow main contents.
- Flush and transfer in the same cycle: the transfer still counts downstream (the downstream stage sampled it), then the state is EMPTY.
- Flush while in SKID_FULL: both entries are dropped, `count_o`=0 next cycle.

## Test plan
- Reset: drive `rst_n_i`=0 asynchronously mid-cycle with `count_o`=2 → outputs immediately `valid_o`=0, `ctrl_o`=0, `data_o`=0, `ready_o`=1, `count_o`=0.
- Streaming: 8 back-to-back entries, `data_i`=0x1..0x8, `ctrl_i`=8'hA5, `ready_i`=1 → `data_o` 0x1..0x8 on consecutive cycles, 1-cycle latency, `ready_o` constantly 1.
- Skid stall (SKID=1): send 0x10, 0x11, 0x12 and drop `ready_i` after the first is presented →
  - 0x11 is captured in skid, `count_o`=2, `ready_o`=0 next cycle, 0x12 is held upstream.
  - On raising `ready_i`, the order 0x10, 0x11, 0x12 is delivered with no loss or duplicate.
- Bubble: `valid_i`=0 for 3 cycles between entries with `ctrl_i`=8'hFF → `ctrl_o`=0 during the gap, `data_o` unchanged.
- Flush: `count_o`=2 with `valid_i`=1 and `flush_i`=1 → next cycle `valid_o`=0, `count_o`=0, `ready_o`=1. The incoming entry never appears on `data_o`.
- SKID=0 build with `DATA_W`=64, `CTRL_W`=4: random `valid_i`/`ready_i` over 1000 cycles → the scoreboard matches in order, and `ready_o` == `!valid_o | ready_i` every cycle.
